// File: rtl/lpc_host_pkg.sv
// lpc_host_pkg
//   Shared LPC host definitions: cycle-type and SYNC nibble codes, the host
//   FSM state encoding, response status codes and a nibble-select helper.
//   No ports; imported by lpc_host.
package lpc_host_pkg;

  // LPC START / cycle-type / turnaround nibbles
  localparam logic [3:0] LPC_START      = 4'b0000;
  localparam logic [3:0] LPC_CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] LPC_CYC_IO_WR  = 4'b0010;
  localparam logic [3:0] LPC_TAR        = 4'b1111;

  // SYNC codes driven by the peripheral
  localparam logic [3:0] LPC_SYNC_READY = 4'b0000;
  localparam logic [3:0] LPC_SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] LPC_SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] LPC_SYNC_ERROR = 4'b1010;

  // Response status
  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_SYNC_ERR = 2'b01;
  localparam logic [1:0] RSP_ABORT    = 2'b10;

  // Host FSM states; ADDR, WDATA, RDATA and ABORT repeat under the nibble counter
  typedef enum logic [3:0] {
    LPC_HST_IDLE      = 4'd0,
    LPC_HST_START     = 4'd1,
    LPC_HST_CYCTYPE   = 4'd2,
    LPC_HST_ADDR      = 4'd3,
    LPC_HST_WDATA     = 4'd4,
    LPC_HST_TAR1      = 4'd5,
    LPC_HST_TAR2      = 4'd6,
    LPC_HST_SYNC      = 4'd7,
    LPC_HST_RDATA     = 4'd8,
    LPC_HST_PTAR1     = 4'd9,
    LPC_HST_PTAR2     = 4'd10,
    LPC_HST_ABORT     = 4'd11,
    LPC_HST_ABORT_END = 4'd12,
    LPC_HST_DONE      = 4'd13
  } lpc_hst_state_e;

  // Address goes out most-significant nibble first
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lpc_host.sv
// lpc_host
//   LPC host-side initiator. Accepts one I/O read/write request at a time from
//   a local master, runs the LPC I/O cycle on LFRAME#/LAD[3:0] and returns
//   read data plus completion status.
// Ports
//   clk_i        in    LPC clock, all logic on posedge
//   rst_i        in    synchronous reset, active high
//   req_valid_i  in    request valid
//   req_ready_o  out   high only in IDLE (and not in reset)
//   req_write_i  in    1 = I/O write, 0 = I/O read
//   req_addr_i   in    [15:0] I/O address
//   req_wdata_i  in    [7:0] write data
//   rsp_valid_o  out   one-cycle completion pulse
//   rsp_rdata_o  out   [7:0] read data (00 for writes and aborts)
//   rsp_status_o out   [1:0] 00 ok, 01 SYNC error, 10 timeout/abort
//   lframe_o     out   LFRAME#, active low
//   lad_bus      inout [3:0] LAD, driven only in host-drive states
module lpc_host
  import lpc_host_pkg::*;
#(
  parameter int NORESP_LIMIT = 3,
  parameter int WAIT_LIMIT   = 1024,
  parameter int ABORT_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_status_o,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus
);

  localparam int CW    = $clog2(WAIT_LIMIT + 1);
  localparam int NIB_W = ($clog2(ABORT_CYCLES) > 2) ? $clog2(ABORT_CYCLES) : 2;

  lpc_hst_state_e state_q, state_d;
  logic [NIB_W-1:0] nib_q, nib_d;

  logic        write_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [1:0]  status_q;
  logic [CW-1:0] sync_cnt_q;
  logic [CW-1:0] noresp_q;

  logic       lframe_q, lframe_d;
  logic [3:0] lad_out_q, lad_out_d;
  logic       lad_oe_q, lad_oe_d;
  logic [7:0] rsp_rdata_q;
  logic [1:0] rsp_status_q;

  logic sync_done, sync_err, sync_wait, sync_last, noresp_last;

  // SYNC decode of whatever the peripheral is driving this cycle
  assign sync_err    = (lad_bus == LPC_SYNC_ERROR);
  assign sync_done   = (lad_bus == LPC_SYNC_READY) || sync_err;
  assign sync_wait   = (lad_bus == LPC_SYNC_SWAIT) || (lad_bus == LPC_SYNC_LWAIT);
  assign sync_last   = (sync_cnt_q == CW'(WAIT_LIMIT - 1));
  assign noresp_last = (noresp_q == CW'(NORESP_LIMIT - 1));

  assign lad_bus      = lad_oe_q ? lad_out_q : 4'bzzzz;
  assign lframe_o     = lframe_q;
  assign req_ready_o  = (state_q == LPC_HST_IDLE) && !rst_i;
  assign rsp_valid_o  = (state_q == LPC_HST_DONE);
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_status_o = rsp_status_q;

  // State register; bus outputs are registered alongside so they line up with the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LPC_HST_IDLE;
      nib_q     <= '0;
      lframe_q  <= 1'b1;
      lad_out_q <= 4'b0000;
      lad_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      lframe_q  <= lframe_d;
      lad_out_q <= lad_out_d;
      lad_oe_q  <= lad_oe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    case (state_q)
      LPC_HST_IDLE:    if (req_valid_i) state_d = LPC_HST_START;
      LPC_HST_START:   state_d = LPC_HST_CYCTYPE;
      LPC_HST_CYCTYPE: begin
        state_d = LPC_HST_ADDR;
        nib_d   = '0;
      end
      LPC_HST_ADDR: begin
        if (nib_q == NIB_W'(3)) begin
          state_d = write_q ? LPC_HST_WDATA : LPC_HST_TAR1;
          nib_d   = '0;
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end
      LPC_HST_WDATA: begin
        if (nib_q[0]) begin
          state_d = LPC_HST_TAR1;
          nib_d   = '0;
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end
      LPC_HST_TAR1:    state_d = LPC_HST_TAR2;
      LPC_HST_TAR2:    state_d = LPC_HST_SYNC;
      // A valid wait code only runs the total counter; anything unrecognised also
      // runs the no-response counter
      LPC_HST_SYNC: begin
        if (sync_done) begin
          state_d = write_q ? LPC_HST_PTAR1 : LPC_HST_RDATA;
          nib_d   = '0;
        end else if (sync_last || (!sync_wait && noresp_last)) begin
          state_d = LPC_HST_ABORT;
          nib_d   = '0;
        end
      end
      LPC_HST_RDATA: begin
        if (nib_q[0]) begin
          state_d = LPC_HST_PTAR1;
          nib_d   = '0;
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end
      LPC_HST_PTAR1:   state_d = LPC_HST_PTAR2;
      LPC_HST_PTAR2:   state_d = LPC_HST_DONE;
      LPC_HST_ABORT: begin
        if (nib_q == NIB_W'(ABORT_CYCLES - 1)) begin
          state_d = LPC_HST_ABORT_END;
          nib_d   = '0;
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end
      LPC_HST_ABORT_END: state_d = LPC_HST_DONE;
      LPC_HST_DONE:      state_d = LPC_HST_IDLE;
      default:           state_d = LPC_HST_IDLE;
    endcase
  end

  // Bus drive for the state being entered, registered at the next edge
  always_comb begin
    lframe_d  = 1'b1;
    lad_out_d = 4'b0000;
    lad_oe_d  = 1'b0;
    case (state_d)
      LPC_HST_START: begin
        lframe_d  = 1'b0;
        lad_oe_d  = 1'b1;
        lad_out_d = LPC_START;
      end
      LPC_HST_CYCTYPE: begin
        lad_oe_d  = 1'b1;
        lad_out_d = write_q ? LPC_CYC_IO_WR : LPC_CYC_IO_RD;
      end
      LPC_HST_ADDR: begin
        lad_oe_d  = 1'b1;
        lad_out_d = addr_nibble(addr_q, nib_d[1:0]);
      end
      LPC_HST_WDATA: begin
        lad_oe_d  = 1'b1;
        lad_out_d = nib_d[0] ? wdata_q[7:4] : wdata_q[3:0];
      end
      LPC_HST_TAR1: begin
        lad_oe_d  = 1'b1;
        lad_out_d = LPC_TAR;
      end
      LPC_HST_ABORT: begin
        lframe_d  = 1'b0;
        lad_oe_d  = 1'b1;
        lad_out_d = LPC_TAR;
      end
      default: ;
    endcase
  end

  // Request capture, SYNC counters, read data and the held response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      status_q     <= RSP_OK;
      sync_cnt_q   <= '0;
      noresp_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= RSP_OK;
    end else begin
      if (state_q == LPC_HST_IDLE && req_valid_i) begin
        write_q    <= req_write_i;
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        rdata_q    <= '0;
        status_q   <= RSP_OK;
        sync_cnt_q <= '0;
        noresp_q   <= '0;
      end
      if (state_q == LPC_HST_SYNC) begin
        if (sync_cnt_q != '1) sync_cnt_q <= sync_cnt_q + CW'(1);
        if (sync_done || sync_wait) noresp_q <= '0;
        else if (noresp_q != '1)    noresp_q <= noresp_q + CW'(1);
        if (sync_err) status_q <= RSP_SYNC_ERR;
        if (state_d == LPC_HST_ABORT) begin
          status_q <= RSP_ABORT;
          rdata_q  <= '0;
        end
      end
      if (state_q == LPC_HST_RDATA) begin
        if (nib_q[0]) rdata_q[7:4] <= lad_bus;
        else          rdata_q[3:0] <= lad_bus;
      end
      if (state_d == LPC_HST_DONE && state_q != LPC_HST_DONE) begin
        rsp_rdata_q  <= write_q ? 8'h00 : rdata_q;
        rsp_status_q <= status_q;
      end
    end
  end

endmodule
